// File: rtl/bank_cmd_sequencer.sv
// bank_cmd_sequencer: per-bank DDR command sequencer.
// Turns one (row, read/write) request into PRE / ACT / RD|WR commands.
// It honours the tRP, tRCD and tRAS spacing rules and drives the open-row
// tracker update interface.
// Optional macro BANK_SEQ_CLOSED_PAGE_EN: precharge the bank after every
// access (closed-page policy). When it is undefined, the row stays open.
module bank_cmd_sequencer #(
  parameter int C_ROW_WIDTH = 14,
  parameter int C_CNT_WIDTH = 4,
  parameter int C_TRP       = 3,
  parameter int C_TRCD      = 3,
  parameter int C_TRAS      = 8
) (
  input  logic                   core_clk,
  input  logic                   core_rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [C_ROW_WIDTH-1:0] req_row,
  input  logic                   req_write,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [1:0]             cmd_type,
  output logic [C_ROW_WIDTH-1:0] cmd_row,
  output logic                   access_done,
  output logic                   update_row,
  output logic [C_ROW_WIDTH-1:0] new_row,
  output logic                   toggle_bank,
  input  logic [C_ROW_WIDTH-1:0] current_row,
  input  logic                   bank_open
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECIDE,
    S_PRE,
    S_ACT,
`ifdef BANK_SEQ_CLOSED_PAGE_EN
    S_ACCESS,
    S_CLOSE
`else
    S_ACCESS
`endif
  } state_t;

  localparam logic [1:0] CMD_ACT = 2'b00;
  localparam logic [1:0] CMD_PRE = 2'b01;

  // A constraint of 0 or 1 cycles needs no wait past the accept cycle, so the
  // load value is clamped at zero.
  localparam logic [C_CNT_WIDTH-1:0] TRP_LD  = C_CNT_WIDTH'((C_TRP  > 0) ? C_TRP  - 1 : 0);
  localparam logic [C_CNT_WIDTH-1:0] TRCD_LD = C_CNT_WIDTH'((C_TRCD > 0) ? C_TRCD - 1 : 0);
  localparam logic [C_CNT_WIDTH-1:0] TRAS_LD = C_CNT_WIDTH'((C_TRAS > 0) ? C_TRAS - 1 : 0);
  localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = C_CNT_WIDTH'(1);

  state_t                   state_q, state_d;
  logic [C_ROW_WIDTH-1:0]   row_q, row_d;
  logic                     write_q, write_d;
  logic [C_CNT_WIDTH-1:0]   trp_q, trp_d;
  logic [C_CNT_WIDTH-1:0]   trcd_q, trcd_d;
  logic [C_CNT_WIDTH-1:0]   tras_q, tras_d;
  logic                     cmd_valid_q, cmd_valid_d;
  logic [1:0]               cmd_type_q, cmd_type_d;
  logic [C_ROW_WIDTH-1:0]   cmd_row_q, cmd_row_d;
  logic                     cmd_accept;

  function automatic logic [C_CNT_WIDTH-1:0] sat_dec(input logic [C_CNT_WIDTH-1:0] v);
    return (v == '0) ? v : v - CNT_ONE;
  endfunction

  assign cmd_accept = cmd_valid_q && cmd_ready && !core_rst;

  // Next-state, timing counters, and registered command outputs.
  // The command outputs are computed from the next state and next counter
  // values. This lets cmd_valid rise in the very cycle the constraint is met.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    write_d     = write_q;
    trp_d       = sat_dec(trp_q);
    trcd_d      = sat_dec(trcd_q);
    tras_d      = sat_dec(tras_q);
    cmd_valid_d = 1'b0;
    cmd_type_d  = cmd_type_q;
    cmd_row_d   = cmd_row_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          row_d   = req_row;
          write_d = req_write;
          state_d = S_DECIDE;
        end
      end
      S_DECIDE: begin
        if (bank_open && (current_row == row_q)) begin
          state_d = S_ACCESS;
        end else if (bank_open) begin
          state_d = S_PRE;
        end else begin
          state_d = S_ACT;
        end
      end
      S_PRE: begin
        if (cmd_accept) begin
          trp_d   = TRP_LD;
          state_d = S_ACT;
        end
      end
      S_ACT: begin
        if (cmd_accept) begin
          trcd_d  = TRCD_LD;
          tras_d  = TRAS_LD;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cmd_accept) begin
`ifdef BANK_SEQ_CLOSED_PAGE_EN
          state_d = S_CLOSE;
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef BANK_SEQ_CLOSED_PAGE_EN
      S_CLOSE: begin
        if (cmd_accept) begin
          trp_d   = TRP_LD;
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Offer the command of the state being entered, once its gate counter is 0.
    case (state_d)
      S_PRE: begin
        cmd_valid_d = (tras_d == '0);
        cmd_type_d  = CMD_PRE;
      end
      S_ACT: begin
        cmd_valid_d = (trp_d == '0);
        cmd_type_d  = CMD_ACT;
      end
      S_ACCESS: begin
        cmd_valid_d = (trcd_d == '0);
        cmd_type_d  = {1'b1, write_d};
      end
`ifdef BANK_SEQ_CLOSED_PAGE_EN
      S_CLOSE: begin
        cmd_valid_d = (tras_d == '0);
        cmd_type_d  = CMD_PRE;
      end
`endif
      default: begin
        cmd_valid_d = 1'b0;
      end
    endcase
    cmd_row_d = row_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      write_q     <= 1'b0;
      trp_q       <= '0;
      trcd_q      <= '0;
      tras_q      <= '0;
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= CMD_ACT;
      cmd_row_q   <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      write_q     <= write_d;
      trp_q       <= trp_d;
      trcd_q      <= trcd_d;
      tras_q      <= tras_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_type_q  <= cmd_type_d;
      cmd_row_q   <= cmd_row_d;
    end
  end

  // The pulses coincide with the accept cycle, so the tracker sees the change
  // on the following cycle.
  assign req_ready   = (state_q == S_IDLE) && !core_rst;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_type    = cmd_type_q;
  assign cmd_row     = cmd_row_q;
  assign new_row     = cmd_row_q;
  assign access_done = cmd_accept && (state_q == S_ACCESS);
  assign update_row  = cmd_accept && (state_q == S_ACT);
`ifdef BANK_SEQ_CLOSED_PAGE_EN
  assign toggle_bank = cmd_accept && ((state_q == S_ACT) || (state_q == S_PRE) ||
                                      (state_q == S_CLOSE));
`else
  assign toggle_bank = cmd_accept && ((state_q == S_ACT) || (state_q == S_PRE));
`endif

endmodule

// File: doc/bank_cmd_sequencer.md
# bank_cmd_sequencer

Per-bank command sequencer that turns a single access request (row, read/write) into the DDR command sequence needed to service it: PRECHARGE, ACTIVATE, then READ or WRITE. It sits between the scheduler's per-bank request queue and the command arbiter. It drives the row/bank update interface (`update_row`/`new_row`/`toggle_bank`) consumed by the per-bank open-row tracker, and reads back that tracker's `current_row`/`bank_open` to detect row hits and misses.

## Interface
- `C_ROW_WIDTH`, 14, row address width
- `C_CNT_WIDTH`, 4, timing counter width; every `C_T*` must be ≤ 2^C_CNT_WIDTH−1
- `C_TRP`, 3, min cycles from PRE accept to ACT valid
- `C_TRCD`, 3, min cycles from ACT accept to RD/WR valid
- `C_TRAS`, 8, min cycles from ACT accept to PRE valid

Ports:
- `core_clk` in 1: sole clock, rising edge
- `core_rst` in 1: reset, synchronous, active-high
- `req_valid` in 1: request present
- `req_ready` out 1: request accepted when `req_valid && req_ready`
- `req_row` in C_ROW_WIDTH: target row
- `req_write` in 1: 1 = WRITE, 0 = READ
- `cmd_valid` out 1: command offered
- `cmd_ready` in 1: arbiter accepts command
- `cmd_type` out 2: 00 ACT, 01 PRE, 10 RD, 11 WR
- `cmd_row` out C_ROW_WIDTH: row for ACT; captured request row otherwise
- `access_done` out 1: one-cycle pulse on RD/WR accept
- `update_row` out 1: one-cycle pulse on ACT accept
- `new_row` out C_ROW_WIDTH: row written to tracker (equals `cmd_row`)
- `toggle_bank` out 1: one-cycle pulse on ACT or PRE accept
- `current_row` in C_ROW_WIDTH: tracker's open row
- `bank_open` in 1: tracker's open flag

## Operation
- States: IDLE, DECIDE, PRE, ACT, ACCESS, CLOSE (CLOSE exists only with the macro).
- IDLE: `req_ready`=1. On accept, register `req_row`/`req_write` and go to DECIDE.
- DECIDE: takes one cycle and emits no command.
  - `bank_open && current_row==row` → ACCESS.
  - `bank_open` with a different row → PRE.
  - `!bank_open` → ACT.
- PRE: `cmd_type`=01. Valid once the tRAS counter reads 0. On accept, pulse `toggle_bank`, load tRP counter = C_TRP−1, go to ACT.
- ACT: `cmd_type`=00. Valid once the tRP counter reads 0. On accept, pulse `update_row` and `toggle_bank`, set `new_row`=row, load tRCD = C_TRCD−1 and tRAS = C_TRAS−1, go to ACCESS.
- ACCESS: `cmd_type`=1,`req_write`. Valid once the tRCD counter reads 0. On accept, pulse `access_done`, go to IDLE.
- Counters:
  - Each decrements every cycle and saturates at 0.
  - A counter at 0 is a satisfied constraint.
  - A parameter value of 0 or 1 means no wait beyond the accept cycle.
- Handshake rules:
  - Once asserted, `cmd_valid`, `cmd_type` and `cmd_row` hold stable until accept.
  - `req_ready` is low in every state except IDLE.
- Width: `current_row` vs. row is a full-width equality compare.
- Reset:
  - State returns to IDLE and all counters clear.
  - Outputs: `req_ready`=0 during reset and 1 from the first cycle after; `cmd_valid`=0; `cmd_type`=00; `cmd_row`/`new_row`=0; `access_done`/`update_row`/`toggle_bank`=0.
  - A reset mid-sequence abandons the request with no further command.
  - The tracker must share `core_rst`; the bank is then treated as closed.

## Timing
- Row hit, `cmd_ready`=1, counters idle: request accepted cycle 0, DECIDE cycle 1, RD/WR valid and accepted cycle 2, `access_done` cycle 2.
- Closed bank (defaults): ACT at cycle 2, RD/WR at cycle 2+C_TRCD = 5.
- Row miss (defaults, tRAS expired): PRE at 2, ACT at 5, RD/WR at 8.
- Tracker state is visible the cycle after a toggle. A request issued back-to-back in IDLE therefore sees the updated `bank_open`/`current_row` in DECIDE.
- `cmd_ready` low stalls the state indefinitely. Counters keep decrementing during the stall.

## Configuration
- `BANK_SEQ_CLOSED_PAGE_EN` defined:
  - After an RD/WR accept, go to CLOSE rather than IDLE.
  - CLOSE offers PRE, gated by tRAS. On accept, pulse `toggle_bank`, load tRP, go to IDLE.
  - `access_done` still pulses on the RD/WR accept.
- Undefined (open page): the row stays open after an access and CLOSE is not built.

## Test plan
- Reset, then `bank_open`=0, request row 0x12 read, `cmd_ready`=1 → ACT row 0x12 at cycle 2 with `update_row`/`toggle_bank` pulses and `new_row`=0x12; RD at cycle 5; `access_done` at 5.
- `bank_open`=1, `current_row`=0x12, request row 0x12 write → WR at cycle 2 with no ACT/PRE and no toggles.
- Immediately after an ACT, a row miss to 0x34 → PRE is held off until C_TRAS has elapsed since the ACT accept; ACT 0x34 follows C_TRP cycles later; RD follows C_TRCD cycles after that.
- Hold `cmd_ready`=0 for 4 cycles during ACT → `cmd_valid`, `cmd_type`=00 and `cmd_row` are stable for all 4 cycles; a single `update_row` pulse on accept.
- Assert `core_rst` during the tRCD wait → next cycle all outputs are at reset values and no RD is issued.
- With `BANK_SEQ_CLOSED_PAGE_EN`, closed-bank read → ACT@2, RD@5, PRE at the earliest tRAS-legal cycle (ACT+8 = 10), then `req_ready`=1.
